block_tx_serializer: RTL and testbench

- Transmit-side counterpart of the receive-side byte-to-block assembler.
- Accepts one 128-bit block (AES ciphertext) via valid/ready and shifts it out as 16 bytes through the UART transmitter's txDataIN/txLoadIN/txReadyOUT handshake.
- Sits between the AES core output register and the UART instance in the top level.
- Replaces the direct rxData-to-txData loopback path.

---
 rtl/cipher_pkg.sv | 14 +
 rtl/block_tx_serializer.sv | 157 +++++++++++++++
 tb/tb_block_tx_serializer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_pkg.sv
// Constants and serializer state encoding shared by the cipher block
// assembler (receive side) and serializer (transmit side).
package cipher_pkg;
    localparam int BLOCK_W     = 128;
    localparam int BYTE_W      = 8;
    localparam int BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_ACK   = 2'd2,
        WAIT_READY = 2'd3
    } tx_state_e;
endpackage

// File: rtl/block_tx_serializer.sv
// Takes one cipher block over valid/ready and feeds it byte by byte into the
// UART transmitter's load/ready handshake, with an ack timeout that latches an error.
module block_tx_serializer #(
    parameter int BLOCK_BYTES = cipher_pkg::BLOCK_BYTES,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                     clockIN,
    input  logic                     nResetIN,
    input  logic [8*BLOCK_BYTES-1:0] blockDataIN,
    input  logic                     blockValidIN,
    output logic                     blockReadyOUT,
    output logic [7:0]               txDataOUT,
    output logic                     txLoadOUT,
    input  logic                     txReadyIN,
    output logic                     busyOUT,
    output logic                     doneOUT,
    output logic                     errorOUT,
    output logic [1:0]               dbgStateOUT
);
    import cipher_pkg::*;

    localparam int BLK_W = BYTE_W * BLOCK_BYTES;
    localparam int CNT_W = $clog2(BLOCK_BYTES + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BLOCK_BYTES);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(ACK_TIMEOUT - 1);

    // Block side: a block transfers on any rising edge where blockValidIN and
    // blockReadyOUT are both high; the whole word is captured on that edge.
    // UART side: a byte is offered with txLoadOUT held high until the UART
    // drops txReadyIN, and the next byte waits for txReadyIN to return high.

    tx_state_e              r_state;
    tx_state_e              w_state_next;
    logic [BLK_W-1:0]       r_shift;
    logic [BLK_W-1:0]       w_shift_next;
    logic [CNT_W-1:0]       r_count;
    logic [TMO_W-1:0]       r_tmo;
    logic [BYTE_W-1:0]      r_tx_data;
    logic [BYTE_W-1:0]      w_cur_byte;
    logic                   r_tx_load;
    logic                   r_done;
    logic                   r_error;
    logic                   r_ready_en;
    logic                   w_capture;
    logic                   w_load;
    logic                   w_ack;
    logic                   w_timeout;
    logic                   w_finish;

    assign w_cur_byte   = MSB_FIRST ? r_shift[BLK_W-1 -: BYTE_W] : r_shift[BYTE_W-1:0];
    assign w_shift_next = MSB_FIRST ? {r_shift[BLK_W-BYTE_W-1:0], {BYTE_W{1'b0}}}
                                    : {{BYTE_W{1'b0}}, r_shift[BLK_W-1:BYTE_W]};

    always_ff @(posedge clockIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_ack        = 1'b0;
        w_timeout    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (blockValidIN && r_ready_en) begin
                    w_capture    = 1'b1;
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (txReadyIN) begin
                    w_load       = 1'b1;
                    w_state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // An ack arriving on the last allowed cycle still counts.
                if (!txReadyIN) begin
                    w_ack        = 1'b1;
                    w_state_next = WAIT_READY;
                end else if (r_tmo == TMO_LIMIT) begin
                    w_timeout    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            WAIT_READY: begin
                if (txReadyIN) begin
                    if (r_count == LAST_CNT) begin
                        w_finish     = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = LOAD;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clockIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_shift    <= '0;
            r_count    <= '0;
            r_tmo      <= '0;
            r_tx_data  <= '0;
            r_tx_load  <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            r_done     <= w_finish;

            if (w_capture) begin
                r_shift <= blockDataIN;
                r_count <= '0;
            end else if (w_ack) begin
                r_shift <= w_shift_next;
                r_count <= r_count + 1'b1;
            end

            if (w_load) begin
                r_tx_data <= w_cur_byte;
                r_tx_load <= 1'b1;
            end else if (w_ack || w_timeout) begin
                r_tx_load <= 1'b0;
            end

            if (w_load) begin
                r_tmo <= '0;
            end else if (r_state == WAIT_ACK && !w_ack && !w_timeout) begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign blockReadyOUT = (r_state == IDLE) && r_ready_en;
    assign busyOUT       = (r_state != IDLE);
    assign txDataOUT     = r_tx_data;
    assign txLoadOUT     = r_tx_load;
    assign doneOUT       = r_done;
    assign errorOUT      = r_error;
    assign dbgStateOUT   = r_state;

endmodule

// File: tb/tb_block_tx_serializer.sv
// Directed bench for block_tx_serializer: MSB-first and LSB-first instances share
// one UART model; a third instance with a short ack timeout is driven by hand.
module tb_block_tx_serializer;

    localparam logic [127:0] BLK_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BLK_B = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] BLK_C = 128'hfedcba98765432100123456789abcdef;

    // clock / reset
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // shared stimulus for the MSB-first and LSB-first instances
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         hold_low;
    logic         m_rdy;
    logic         tx_rdy;
    assign tx_rdy = m_rdy & ~hold_low;

    logic       m_ready, m_load, m_busy, m_done, m_error;
    logic [7:0] m_data;
    logic [1:0] m_dbg;
    logic       l_ready, l_load, l_busy, l_done, l_error;
    logic [7:0] l_data;
    logic [1:0] l_dbg;

    // hand-driven timeout instance
    logic [127:0] t_blk;
    logic         t_valid;
    logic         t_rdy;
    logic         t_ready, t_load, t_busy, t_done, t_error;
    logic [7:0]   t_data;
    logic [1:0]   t_dbg;

    block_tx_serializer #(.BLOCK_BYTES(16), .MSB_FIRST(1'b1), .ACK_TIMEOUT(1023)) dut_msb (
        .clockIN(clk), .nResetIN(rst_n), .blockDataIN(blk_data), .blockValidIN(blk_valid),
        .blockReadyOUT(m_ready), .txDataOUT(m_data), .txLoadOUT(m_load), .txReadyIN(tx_rdy),
        .busyOUT(m_busy), .doneOUT(m_done), .errorOUT(m_error), .dbgStateOUT(m_dbg)
    );

    block_tx_serializer #(.BLOCK_BYTES(16), .MSB_FIRST(1'b0), .ACK_TIMEOUT(1023)) dut_lsb (
        .clockIN(clk), .nResetIN(rst_n), .blockDataIN(blk_data), .blockValidIN(blk_valid),
        .blockReadyOUT(l_ready), .txDataOUT(l_data), .txLoadOUT(l_load), .txReadyIN(tx_rdy),
        .busyOUT(l_busy), .doneOUT(l_done), .errorOUT(l_error), .dbgStateOUT(l_dbg)
    );

    block_tx_serializer #(.BLOCK_BYTES(16), .MSB_FIRST(1'b1), .ACK_TIMEOUT(15)) dut_tmo (
        .clockIN(clk), .nResetIN(rst_n), .blockDataIN(t_blk), .blockValidIN(t_valid),
        .blockReadyOUT(t_ready), .txDataOUT(t_data), .txLoadOUT(t_load), .txReadyIN(t_rdy),
        .busyOUT(t_busy), .doneOUT(t_done), .errorOUT(t_error), .dbgStateOUT(t_dbg)
    );

    // scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] got_msb[$];
    logic [7:0] got_lsb[$];
    int n_checks = 0;
    int n_fail   = 0;

    // UART model: takes a loaded byte after seeing txLoad for 3 cycles, then busy 10 cycles
    int m_wait;
    int m_busy_cnt;
    initial begin
        m_rdy = 1'b1;
        m_wait = 0;
        m_busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_rdy = 1'b1;
                m_wait = 0;
                m_busy_cnt = 0;
            end else if (m_busy_cnt != 0) begin
                m_busy_cnt = m_busy_cnt - 1;
                if (m_busy_cnt == 0) m_rdy = 1'b1;
            end else if (m_rdy && m_load) begin
                if (m_wait == 2) begin
                    m_rdy = 1'b0;
                    m_busy_cnt = 10;
                    m_wait = 0;
                    got_msb.push_back(m_data);
                    got_lsb.push_back(l_data);
                end else begin
                    m_wait = m_wait + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares one captured byte stream against exp_q, consuming both.
    task automatic check_stream(input string tag, input bit use_lsb);
        logic [7:0] obs;
        check({tag, "_len"}, 128'(use_lsb ? got_lsb.size() : got_msb.size()), 128'(exp_q.size()));
        for (int k = 0; exp_q.size() > 0; k++) begin
            obs = 8'hxx;
            if (use_lsb) begin
                if (got_lsb.size() > 0) obs = got_lsb.pop_front();
            end else begin
                if (got_msb.size() > 0) obs = got_msb.pop_front();
            end
            check($sformatf("%s_byte%0d", tag, k), 128'(obs), 128'(exp_q.pop_front()));
        end
        if (use_lsb) got_lsb.delete(); else got_msb.delete();
    endtask

    // Runs until the MSB-first instance pulses done; optional 50-cycle UART stall
    task automatic wait_done(input int stall_at, output bit seen, output int loads,
                             output bit bad_hs, output bit bad_stall);
        bit prev_load;
        bit stalled;
        seen = 1'b0;
        bad_hs = 1'b0;
        bad_stall = 1'b0;
        stalled = 1'b0;
        prev_load = m_load;
        loads = m_load ? 1 : 0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            if (m_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (m_busy !== 1'b1 || m_ready !== 1'b0) bad_hs = 1'b1;
                if (m_load && !prev_load) loads++;
                prev_load = m_load;
                if (stall_at >= 0 && !stalled && got_msb.size() == stall_at) begin
                    stalled = 1'b1;
                    hold_low = 1'b1;
                    repeat (50) begin
                        @(negedge clk);
                        if (m_load !== 1'b0 || got_msb.size() != stall_at || m_done !== 1'b0)
                            bad_stall = 1'b1;
                    end
                    hold_low = 1'b0;
                    prev_load = m_load;
                end
            end
        end
        if (stall_at >= 0 && !stalled) bad_stall = 1'b1;
    endtask

    initial begin
        bit seen;
        int loads;
        bit bad_hs;
        bit bad_stall;
        bit bad;
        bit bad_done;
        int n;
        logic [7:0] c_bytes [8];
        c_bytes = '{8'hfe, 8'hdc, 8'hba, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};

        rst_n = 1'b0;
        blk_data = '0;
        blk_valid = 1'b0;
        hold_low = 1'b0;
        t_blk = '0;
        t_valid = 1'b0;
        t_rdy = 1'b1;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_tx_data", 128'(m_data), 128'(8'h00));
        check("rst_tx_load", 128'(m_load), 128'(1'b0));
        check("rst_busy", 128'(m_busy), 128'(1'b0));
        check("rst_done", 128'(m_done), 128'(1'b0));
        check("rst_error", 128'(m_error), 128'(1'b0));
        check("rst_ready", 128'(m_ready), 128'(1'b0));
        check("rst_state", 128'(m_dbg), 128'(2'd0));
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 128'(m_ready), 128'(1'b0));
        @(negedge clk);
        check("ready_after_release", 128'(m_ready), 128'(1'b1));
        check("t_ready_after_release", 128'(t_ready), 128'(1'b1));

        // block A, both byte orders, 2-cycle load latency
        blk_data = BLK_A;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        blk_data = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        check("a_busy", 128'(m_busy), 128'(1'b1));
        check("a_ready_low", 128'(m_ready), 128'(1'b0));
        check("a_load_cycle1", 128'(m_load), 128'(1'b0));
        @(negedge clk);
        check("a_load_cycle2", 128'(m_load), 128'(1'b1));
        check("a_first_msb", 128'(m_data), 128'(8'h00));
        check("a_first_lsb", 128'(l_data), 128'(8'hff));
        wait_done(-1, seen, loads, bad_hs, bad_stall);
        check("a_done_seen", 128'(seen), 128'(1'b1));
        check("a_loads", 128'(loads), 128'(16));
        check("a_busy_ready_during", 128'(bad_hs), 128'(1'b0));
        check("a_ready_at_done", 128'(m_ready), 128'(1'b1));
        check("a_busy_at_done", 128'(m_busy), 128'(1'b0));
        check("a_lsb_done", 128'(l_done), 128'(1'b1));
        // block B presented in the done cycle of A
        blk_data = BLK_B;
        blk_valid = 1'b1;
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h11 * k));
        check_stream("a_msb", 1'b0);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h11 * (15 - k)));
        check_stream("a_lsb", 1'b1);
        @(negedge clk);
        blk_valid = 1'b0;
        blk_data = '0;
        check("b2b_capture", 128'(m_busy), 128'(1'b1));
        check("done_one_cycle", 128'(m_done), 128'(1'b0));

        // block B with a 50-cycle UART stall after 5 bytes
        wait_done(5, seen, loads, bad_hs, bad_stall);
        check("b_done_seen", 128'(seen), 128'(1'b1));
        check("b_loads", 128'(loads), 128'(16));
        check("b_busy_ready_during", 128'(bad_hs), 128'(1'b0));
        check("b_stall_no_progress", 128'(bad_stall), 128'(1'b0));
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h0f * (k + 1)));
        check_stream("b_msb", 1'b0);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h0f * (16 - k)));
        check_stream("b_lsb", 1'b1);

        // timeout instance: no load while txReady is low, then ack never comes
        @(negedge clk);
        t_rdy = 1'b0;
        t_blk = BLK_A;
        t_valid = 1'b1;
        @(negedge clk);
        t_valid = 1'b0;
        check("t_busy", 128'(t_busy), 128'(1'b1));
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (t_load !== 1'b0 || t_dbg !== 2'd1) bad = 1'b1;
        end
        check("t_no_load_not_ready", 128'(bad), 128'(1'b0));
        t_rdy = 1'b1;
        @(negedge clk);
        check("t_load", 128'(t_load), 128'(1'b1));
        check("t_byte0", 128'(t_data), 128'(8'h00));
        bad = 1'b0;
        bad_done = 1'b0;
        for (int i = 2; i <= 15; i++) begin
            @(negedge clk);
            if (t_error !== 1'b0 || t_load !== 1'b1) bad = 1'b1;
            if (t_done !== 1'b0) bad_done = 1'b1;
        end
        check("t_hold_before_timeout", 128'(bad), 128'(1'b0));
        @(negedge clk);
        check("t_error_set", 128'(t_error), 128'(1'b1));
        check("t_load_dropped", 128'(t_load), 128'(1'b0));
        check("t_state_idle", 128'(t_dbg), 128'(2'd0));
        check("t_ready_again", 128'(t_ready), 128'(1'b1));
        if (t_done !== 1'b0) bad_done = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (t_done !== 1'b0) bad_done = 1'b1;
        end
        check("t_error_sticky", 128'(t_error), 128'(1'b1));
        check("t_no_done", 128'(bad_done), 128'(1'b0));

        // block C interrupted by reset while byte 8 is being offered
        blk_data = BLK_C;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        n = 0;
        while (got_msb.size() < 8 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("c_reached_byte7", 128'(got_msb.size() >= 8), 128'(1'b1));
        n = 0;
        while (m_load !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("c_load_before_reset", 128'(m_load), 128'(1'b1));
        for (int k = 0; k < 8; k++) exp_q.push_back(c_bytes[k]);
        while (got_msb.size() > 8) void'(got_msb.pop_back());
        check_stream("c_msb", 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_load", 128'(m_load), 128'(1'b0));
        check("mid_rst_data", 128'(m_data), 128'(8'h00));
        check("mid_rst_busy", 128'(m_busy), 128'(1'b0));
        check("mid_rst_ready", 128'(m_ready), 128'(1'b0));
        check("mid_rst_state", 128'(m_dbg), 128'(2'd0));
        check("mid_rst_t_error", 128'(t_error), 128'(1'b0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got_msb.delete();
        got_lsb.delete();
        @(negedge clk);

        // fresh block after reset starts from byte 0
        blk_data = BLK_A;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        wait_done(-1, seen, loads, bad_hs, bad_stall);
        check("d_done_seen", 128'(seen), 128'(1'b1));
        check("d_loads", 128'(loads), 128'(16));
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h11 * k));
        check_stream("d_msb", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
